// File: rtl/draw_score_hi_seq.sv
// High-score overlay: tracks the running maximum score, converts it to BCD with an
// iterative double-dabble and draws "HI" plus NUM_DIGITS digits as 8x14 segment glyphs.

module draw_score_hi_seg #(
    parameter int POS_X = 0,
    parameter int POS_Y = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] num,
    output logic       hit
);
    logic [10:0] dx;
    logic [10:0] dy;
    logic [6:0]  seg;  // {a,b,c,d,e,f,g}
    logic        in_box, top, mid, bot, left, right, upper, lower;

    // NOTE: every signal driven in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        dx = {1'b0, x} - 11'(POS_X);
        dy = {1'b0, y} - 11'(POS_Y);
        case (num)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        in_box = (dx < 11'd8) && (dy < 11'd14);
        top    = dy < 11'd2;
        mid    = (dy == 11'd6) || (dy == 11'd7);
        bot    = dy >= 11'd12;
        left   = dx < 11'd2;
        right  = dx >= 11'd6;
        upper  = dy < 11'd8;
        lower  = dy >= 11'd6;
        hit    = in_box && ((seg[6] && top) || (seg[5] && right && upper) ||
                            (seg[4] && right && lower) || (seg[3] && bot) ||
                            (seg[2] && left && lower) || (seg[1] && left && upper) ||
                            (seg[0] && mid));
    end
endmodule

module draw_score_hi_alpha #(
    parameter int POS_X = 0,
    parameter int POS_Y = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] select_char,
    output logic       hit
);
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;

    always_comb begin
        dx     = {1'b0, x} - 11'(POS_X);
        dy     = {1'b0, y} - 11'(POS_Y);
        in_box = (dx < 11'd8) && (dy < 11'd14);
        case (select_char)
            4'd3:    hit = in_box && ((dx < 11'd2) || (dx >= 11'd6) ||
                                      (dy == 11'd6) || (dy == 11'd7));
            4'd4:    hit = in_box && ((dy < 11'd2) || (dy >= 11'd12) ||
                                      (dx == 11'd3) || (dx == 11'd4));
            default: hit = 1'b0;
        endcase
    end
endmodule

module draw_score_hi_seq #(
    parameter int          NUM_DIGITS   = 4,
    parameter int          SCORE_W      = 32,
    parameter int          POS_X        = 455,
    parameter int          POS_Y        = 20,
    parameter int          PITCH        = 15,
    parameter bit          LZ_BLANK     = 1'b0,
    parameter int          BLINK_FRAMES = 64,
    parameter logic [11:0] SCORE_RGB    = 12'haaa
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    input  logic               clear_hi,
    output logic               busy,
    output logic [SCORE_W-1:0] hi_score,
    output logic               new_hi,
    output logic               isScore,
    output logic [11:0]        score_rgb
);
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) < 4) ? 4 : $clog2(BLINK_FRAMES + 1);

    function automatic logic [63:0] max_display(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DISP = max_display(NUM_DIGITS);

    // One double-dabble step: correct each nibble, then shift the next binary bit in.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = b;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (b[4*i +: 4] >= 4'd5) adj[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    typedef enum logic [1:0] {IDLE, COMPARE, CONVERT, COMMIT} state_t;

    state_t             state, state_nx;
    logic [SCORE_W-1:0] cap, pend_val, shreg;
    logic               pend_flag;
    logic [BCD_W-1:0]   bcd, digits;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BLINK_W-1:0] blink;
    logic               accept, saturate;

    assign accept    = cap > hi_score;
    assign saturate  = 64'(cap) > MAX_DISP;
    assign busy      = state != IDLE;
    assign score_rgb = SCORE_RGB;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (score_valid || pend_flag) state_nx = COMPARE;
            COMPARE: if (!accept)      state_nx = IDLE;
                     else if (saturate) state_nx = COMMIT;
                     else               state_nx = CONVERT;
            CONVERT: if (bit_cnt == CNT_W'(SCORE_W - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear_hi) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_score  <= '0;
            cap       <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            shreg     <= '0;
            bcd       <= '0;
            digits    <= '0;
            bit_cnt   <= '0;
            blink     <= '0;
            new_hi    <= 1'b0;
        end else if (clear_hi) begin
            hi_score  <= '0;
            cap       <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            shreg     <= '0;
            bcd       <= '0;
            digits    <= '0;
            bit_cnt   <= '0;
            blink     <= '0;
            new_hi    <= 1'b0;
        end else begin
            new_hi <= 1'b0;
            if (frame_tick && blink != '0) blink <= blink - 1'b1;
            case (state)
                IDLE: begin
                    if (pend_flag) begin
                        cap       <= (score_valid && score > pend_val) ? score : pend_val;
                        pend_flag <= 1'b0;
                        pend_val  <= '0;
                    end else if (score_valid) begin
                        cap <= score;
                    end
                end
                COMPARE: begin
                    if (accept) begin
                        hi_score <= cap;
                        new_hi   <= 1'b1;
                        blink    <= BLINK_W'(BLINK_FRAMES);
                        bit_cnt  <= '0;
                        shreg    <= cap;
                        bcd      <= saturate ? {NUM_DIGITS{4'h9}} : '0;
                    end
                end
                CONVERT: begin
                    bcd     <= dabble_step(bcd, shreg[SCORE_W-1]);
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: digits <= bcd;
                default: ;
            endcase
            // Scores arriving mid-operation collapse into one pending value; only the largest can matter.
            if (state != IDLE && score_valid) begin
                pend_flag <= 1'b1;
                pend_val  <= (pend_flag && pend_val > score) ? pend_val : score;
            end
        end
    end

    logic [NUM_DIGITS-1:0] dig_hit, hide;
    logic                  h_hit, i_hit, blink_hide, lead_zero;

    always_comb begin
        blink_hide = (blink != '0) && blink[3];
        lead_zero  = 1'b1;
        hide       = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lead_zero = lead_zero && (digits[BCD_W-4-4*k +: 4] == 4'd0);
            hide[k]   = blink_hide || (LZ_BLANK && (k != NUM_DIGITS - 1) && lead_zero);
        end
    end

    draw_score_hi_alpha #(.POS_X(POS_X), .POS_Y(POS_Y)) u_h (
        .x(x), .y(y), .select_char(4'd3), .hit(h_hit)
    );
    draw_score_hi_alpha #(.POS_X(POS_X + PITCH), .POS_Y(POS_Y)) u_i (
        .x(x), .y(y), .select_char(4'd4), .hit(i_hit)
    );

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        draw_score_hi_seg #(.POS_X(POS_X + (2 + k) * PITCH), .POS_Y(POS_Y)) u_seg (
            .x(x), .y(y), .num(digits[BCD_W-4-4*k +: 4]), .hit(dig_hit[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) isScore <= 1'b0;
        else        isScore <= h_hit | i_hit | (|(dig_hit & ~hide));
    end
endmodule

// File: tb/tb_draw_score_hi_seq.sv
// Scoreboard bench for draw_score_hi_seq: a monitor checks every new_hi pulse against queued
// expectations, and pixel scans compare the overlay against a glyph-level reference model.

module tb_draw_score_hi_seq;
    localparam int N     = 4;
    localparam int SW    = 32;
    localparam int PX    = 455;
    localparam int PY    = 20;
    localparam int PITCH = 15;
    localparam int BF    = 64;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [9:0]    x = '0, y = '0;
    logic          frame_tick = 1'b0, score_valid = 1'b0, clear_hi = 1'b0;
    logic [SW-1:0] score = '0;

    logic          busy, new_hi, is_score;
    logic [SW-1:0] hi_score;
    logic [11:0]   score_rgb;
    logic          lz_busy, lz_new_hi, lz_is_score;
    logic [SW-1:0] lz_hi_score;
    logic [11:0]   lz_score_rgb;

    always #5 clk = ~clk;

    draw_score_hi_seq #(.NUM_DIGITS(N), .SCORE_W(SW), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_tick(frame_tick), .score(score),
        .score_valid(score_valid), .clear_hi(clear_hi), .busy(busy), .hi_score(hi_score),
        .new_hi(new_hi), .isScore(is_score), .score_rgb(score_rgb)
    );

    draw_score_hi_seq #(.NUM_DIGITS(N), .SCORE_W(SW), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_tick(frame_tick), .score(score),
        .score_valid(score_valid), .clear_hi(clear_hi), .busy(lz_busy), .hi_score(lz_hi_score),
        .new_hi(lz_new_hi), .isScore(lz_is_score), .score_rgb(lz_score_rgb)
    );

    int checks = 0, errors = 0;
    logic [SW-1:0] exp_q[$];
    longint unsigned m_hi = 0;
    int m_blink = 0;
    string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int e);
        longint unsigned p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit seg_on(input string s, input int dx, input int dy);
        bit h = 0;
        for (int i = 0; i < s.len(); i++)
            case (s[i])
                "a": h |= dy < 2;
                "b": h |= dx >= 6 && dy < 8;
                "c": h |= dx >= 6 && dy >= 6;
                "d": h |= dy >= 12;
                "e": h |= dx < 2 && dy >= 6;
                "f": h |= dx < 2 && dy < 8;
                "g": h |= dy == 6 || dy == 7;
                default: ;
            endcase
        return h;
    endfunction

    function automatic bit exp_pixel(input bit lz, input int px, input int py);
        bit lit = 0;
        longint unsigned shown, p;
        int gx, dx, dy, k, dig;
        bit blink_hide;
        shown      = (m_hi > pow10(N) - 1) ? pow10(N) - 1 : m_hi;
        blink_hide = (m_blink != 0) && ((m_blink % 16) >= 8);
        if (py < PY || py >= PY + 14) return 0;
        for (int g = 0; g < N + 2; g++) begin
            gx = PX + g * PITCH;
            if (px >= gx && px < gx + 8) begin
                dx = px - gx;
                dy = py - PY;
                if (g == 0)      lit |= seg_on("bcefg", dx, dy);
                else if (g == 1) lit |= dy < 2 || dy >= 12 || dx == 3 || dx == 4;
                else begin
                    k   = g - 2;
                    p   = pow10(N - 1 - k);
                    dig = int'((shown / p) % 10);
                    if (!(blink_hide || (lz && k != N - 1 && shown < p)))
                        lit |= seg_on(segs[dig], dx, dy);
                end
            end
        end
        return lit;
    endfunction

    function automatic void model_accept(input logic [SW-1:0] v);
        if (longint'(v) > m_hi) begin
            m_hi    = v;
            m_blink = BF;
            exp_q.push_back(v);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && new_hi) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_new_hi: got pulse with hi_score=%0d expected none", hi_score);
            end else begin
                logic [SW-1:0] e;
                e = exp_q.pop_front();
                check("new_hi_value", hi_score, e);
                check("lz_new_hi_value", lz_hi_score, e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [SW-1:0] v);
        @(negedge clk);
        score = v;
        score_valid = 1'b1;
        model_accept(v);
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic timed_score(input logic [SW-1:0] v, output int nbusy, output int nh_cycle, output int nh_count);
        @(negedge clk);
        score = v;
        score_valid = 1'b1;
        model_accept(v);
        nbusy = 0; nh_cycle = 0; nh_count = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            score_valid = 1'b0;
            if (new_hi) begin
                nh_count++;
                if (nh_cycle == 0) nh_cycle = c;
            end
            if (!busy) break;
            nbusy++;
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int c = 0; c < 500 && quiet < 3; c++) begin
            @(negedge clk);
            if (!busy && !lz_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still high after 500 cycles, expected idle");
        end
    endtask

    task automatic scan(input string tag);
        int bad_m = 0, bad_l = 0;
        for (int py = PY - 1; py <= PY + 14; py++)
            for (int px = PX - 1; px <= PX + (N + 2) * PITCH; px++) begin
                @(negedge clk);
                x = 10'(px);
                y = 10'(py);
                @(posedge clk);
                #1;
                if (is_score !== exp_pixel(0, px, py)) begin
                    if (bad_m == 0) $display("  %s main first bad pixel (%0d,%0d) got %b", tag, px, py, is_score);
                    bad_m++;
                end
                if (lz_is_score !== exp_pixel(1, px, py)) begin
                    if (bad_l == 0) $display("  %s lz first bad pixel (%0d,%0d) got %b", tag, px, py, lz_is_score);
                    bad_l++;
                end
            end
        check({tag, "_main_bad_pixels"}, bad_m, 0);
        check({tag, "_lz_bad_pixels"}, bad_l, 0);
    endtask

    function automatic logic [SW-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return SW'($urandom_range(0, 99));
            1:       return SW'($urandom_range(0, 9999));
            2:       return SW'($urandom_range(10000, 99999));
            default: return SW'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int nb, nc, nn;
        logic [SW-1:0] a, b;

        #12;
        check("reset_busy", busy, 0);
        check("reset_hi_score", hi_score, 0);
        check("reset_new_hi", new_hi, 0);
        check("reset_is_score", is_score, 0);
        check("score_rgb", score_rgb, 12'haaa);
        @(negedge clk);
        rst_n = 1'b1;
        scan("reset");

        timed_score(1234, nb, nc, nn);
        check("rec1234_busy_cycles", nb, 34);
        check("rec1234_new_hi_cycle", nc, 2);
        check("rec1234_new_hi_count", nn, 1);
        check("rec1234_hi_score", hi_score, 1234);
        scan("digits_1234");

        timed_score(500, nb, nc, nn);
        check("rej500_busy_cycles", nb, 1);
        check("rej500_new_hi_count", nn, 0);
        check("rej500_hi_score", hi_score, 1234);
        scan("digits_after_reject");

        timed_score(12345, nb, nc, nn);
        check("sat_busy_cycles", nb, 2);
        check("sat_new_hi_cycle", nc, 2);
        check("sat_hi_score", hi_score, 12345);
        scan("saturated");

        @(negedge clk); clear_hi = 1'b1;
        @(negedge clk); clear_hi = 1'b0;
        m_hi = 0; m_blink = 0;
        check("clear_hi_score", hi_score, 0);

        // Second score arrives while the first is converting.
        @(negedge clk); score = 100; score_valid = 1'b1; model_accept(100);
        @(negedge clk); score_valid = 1'b0;
        @(negedge clk); score = 700; score_valid = 1'b1; model_accept(700);
        @(negedge clk); score_valid = 1'b0;
        wait_idle();
        check("pending_hi_score", hi_score, 700);
        scan("pending_0700");

        // clear_hi together with score_valid mid-conversion.
        issue(5000);
        repeat (10) @(negedge clk);
        check("mid_convert_busy", busy, 1);
        clear_hi = 1'b1; score = 9000; score_valid = 1'b1;
        @(negedge clk);
        clear_hi = 1'b0; score_valid = 1'b0;
        m_hi = 0; m_blink = 0;
        check("clear_abort_busy", busy, 0);
        check("clear_abort_hi_score", hi_score, 0);
        repeat (3) @(negedge clk);
        check("clear_ignores_valid", busy, 0);
        scan("cleared");

        issue(7);
        wait_idle();
        scan("hi_7");
        @(negedge clk); x = 535; y = 20;
        for (int t = 0; t < BF + 3; t++) begin
            @(negedge clk); frame_tick = 1'b1;
            if (m_blink > 0) m_blink--;
            @(negedge clk); frame_tick = 1'b0;
            @(negedge clk);
            check("blink_main_pixel", is_score, exp_pixel(0, 535, 20));
            check("blink_lz_pixel", lz_is_score, exp_pixel(1, 535, 20));
        end

        for (int it = 0; it < 24; it++) begin
            a = pick();
            issue(a);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                b = pick();
                issue(b);
            end
            wait_idle();
            check("rand_hi_score", hi_score, m_hi);
            check("rand_lz_hi_score", lz_hi_score, m_hi);
            if (it % 8 == 7) scan("random");
        end

        // Asynchronous reset in the middle of a conversion and a blink.
        @(negedge clk); clear_hi = 1'b1;
        @(negedge clk); clear_hi = 1'b0;
        m_hi = 0; m_blink = 0;
        issue(4321);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_hi_score", hi_score, 0);
        check("async_reset_new_hi", new_hi, 0);
        check("async_reset_is_score", is_score, 0);
        m_hi = 0; m_blink = 0;
        @(negedge clk); rst_n = 1'b1;
        scan("after_reset");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/draw_score_hi_seq.md
Name: draw_score_hi_seq

Overview:
- Clocked, parametrised high-score overlay for the VGA pixel pipeline.
- Tracks the running maximum of scores presented by game logic.
- Converts the high score to BCD with an iterative double-dabble, so there are no divide/modulo operators.
- Drives a NUM_DIGITS-wide "HI" readout through the existing segment and alphabet glyph modules, with saturation, optional leading-zero blanking and a blink on a new record.

Parameters:
- NUM_DIGITS, 4: decimal digits shown (1..8).
- SCORE_W, 32: score width in bits.
- POS_X, 455: x of the "H" glyph; "I" sits at POS_X+PITCH; digit k (k=0 is most significant) sits at POS_X+(2+k)*PITCH.
- POS_Y, 20: y of all glyphs.
- PITCH, 15: horizontal glyph pitch in pixels.
- LZ_BLANK, 0: 1 hides leading-zero digits; the units digit is always shown.
- BLINK_FRAMES, 64: frames the digits blink after a new record.
- SCORE_RGB, 12'haaa: colour of all glyph pixels.

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse per frame
- score  in  SCORE_W  current game score
- score_valid  in  1  one-cycle strobe; score is sampled on this edge
- clear_hi  in  1  one-cycle strobe; zero the high score
- busy  out  1  compare/convert in progress
- hi_score  out  SCORE_W  registered high score
- new_hi  out  1  one-cycle pulse when a new record is accepted
- isScore  out  1  registered: pixel (x,y) is a lit high-score glyph pixel
- score_rgb  out  12  SCORE_RGB constant

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. The following are all 0:
  - hi_score, pending value/flag, BCD shift register, displayed digits
  - busy, new_hi, blink counter, isScore
- score_rgb is constant at SCORE_RGB.
- FSM states: IDLE, COMPARE, CONVERT, COMMIT.
  - IDLE: on score_valid, capture score into cap, go to COMPARE.
  - COMPARE (1 cycle):
    - If cap > hi_score: hi_score <= cap, new_hi pulses in the next cycle, blink counter <= BLINK_FRAMES, go to CONVERT.
    - Otherwise return to IDLE; digits are unchanged.
  - CONVERT: bit counter runs SCORE_W cycles. Each cycle: add 3 to any BCD nibble >= 5, then shift in the next MSB of hi_score.
    - If hi_score > 10^NUM_DIGITS-1, skip conversion (0 cycles) and load all nibbles with 9 (saturation).
  - COMMIT (1 cycle): copy the BCD register to the displayed digits atomically, then go to IDLE. A partial conversion is never displayed.
- busy = 1 in COMPARE, CONVERT and COMMIT.
- Latency, non-saturated path:
  - score_valid sampled at edge 0.
  - COMPARE at cycle 1, CONVERT at cycles 2..SCORE_W+1, COMMIT at SCORE_W+2.
  - New digits drive glyphs from cycle SCORE_W+3.
- Latency, saturated path: new digits drive glyphs from cycle 3.
- score_valid while busy:
  - The value is held in a one-deep pending register, which keeps the larger of the stored and new values.
  - After COMMIT (or a COMPARE reject), a set pending flag is consumed as if score_valid were presented in IDLE.
- clear_hi is synchronous and takes priority over everything in the same cycle. It:
  - zeros hi_score, digits, pending and blink;
  - aborts any conversion and returns to IDLE;
  - does not pulse new_hi.
- Blink:
  - The counter decrements on frame_tick while nonzero.
  - While nonzero, digits are hidden when counter[3]=1.
  - Labels "H" and "I" are never hidden.
- Leading zeros (LZ_BLANK=1): a digit is hidden if it and all more-significant digits are 0, except the units digit.
- Pixel path:
  - isScore registered = OR of all glyph hits for the current (x,y), after blanking/blink masking.
  - One cycle latency from x,y.
  - Glyph hits are computed with the segment instances (num = digit nibble) and the alphabet instances (select_char 3 for "H", 4 for "I").
- Widths: comparison is unsigned SCORE_W. The BCD register is 4*NUM_DIGITS bits. No wrap-around: scores above the maximum saturate the display only; hi_score holds the full value.

Test Plan:
- Reset, then score=1234 with score_valid; sample after 35 cycles (SCORE_W=32) -> new_hi pulses once at cycle 2, busy high cycles 1-34, digits 1,2,3,4, hi_score=1234.
- hi_score=1234, then score=500 -> returns to IDLE after COMPARE, no new_hi, digits still 1234, busy high one cycle.
- score=12345 (NUM_DIGITS=4) -> hi_score=12345, digits 9,9,9,9 from cycle 3.
- score=100 then score=700 two cycles later (while busy) -> pending serviced, final hi_score=700, digits 0,7,0,0, new_hi pulses twice.
- clear_hi asserted mid-CONVERT together with score_valid -> IDLE next cycle, hi_score=0, digits 0, busy=0, valid ignored.
- After a new record, 64 frame_ticks at pixel (535,20) on a lit units segment -> isScore toggles every 8 frames, then steady 1. With LZ_BLANK=1 and hi_score=7, only the units digit and "HI" are lit. Asserting rst_n=0 mid-blink clears everything immediately.
